// File: rtl/pipe_stage_skid_reg_if.sv
// Valid/ready handshake bundle for a pipeline stage register.
// Upstream (in_*) and downstream (out_*) sides of one stage.
interface pipe_stage_skid_reg_if #(
    parameter int PAYLOAD_W = 71
);
    logic                 in_valid;
    logic [PAYLOAD_W-1:0] in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic [PAYLOAD_W-1:0] out_data;
    logic                 out_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Handshaked pipeline stage register with a two-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
module pipe_stage_skid_reg #(
    parameter int PAYLOAD_W     = 71,
    parameter bit CLEAR_INVALID = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    pipe_stage_skid_reg_if.slave bus,
    output logic [1:0]           count,
    output logic [CNT_W-1:0]     stall_cnt,
    input  logic                 stall_clr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [PAYLOAD_W-1:0] m_data;
    logic [PAYLOAD_W-1:0] m_data_d;
    logic [PAYLOAD_W-1:0] s_data;
    logic [PAYLOAD_W-1:0] s_data_d;
    logic                 m_valid;
    logic                 s_valid;
    logic                 accept;
    logic                 drain;

    assign m_valid = (state_q != EMPTY);
    assign s_valid = (state_q == FULL);

    // in_ready depends only on registered state, never on out_ready
    assign bus.in_ready  = ~s_valid & reset;
    assign bus.out_valid = m_valid;
    assign bus.out_data  = (CLEAR_INVALID && !m_valid) ? '0 : m_data;

    assign accept = bus.in_valid & bus.in_ready;
    assign drain  = m_valid & bus.out_ready;
    assign count  = state_q;

    always_comb begin
        state_d  = state_q;
        m_data_d = m_data;
        s_data_d = s_data;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d  = ONE;
                    m_data_d = bus.in_data;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    m_data_d = bus.in_data;
                end else if (accept) begin
                    state_d  = FULL;
                    s_data_d = bus.in_data;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_d  = ONE;
                    m_data_d = s_data;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (flush) begin
            state_d  = EMPTY;
            m_data_d = '0;
            s_data_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= EMPTY;
            m_data  <= '0;
            s_data  <= '0;
        end else begin
            state_q <= state_d;
            m_data  <= m_data_d;
            s_data  <= s_data_d;
        end
    end

    // Clear wins over a simultaneous stall; flush leaves the count alone
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (m_valid && !bus.out_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: streaming, skid,
// flush, stall counter and reset behaviour.
module tb_pipe_stage_skid_reg;

    localparam int PW = 71;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          flush;
    logic [1:0]    count;
    logic [CW-1:0] stall_cnt;
    logic          stall_clr;

    pipe_stage_skid_reg_if #(.PAYLOAD_W(PW)) bus ();

    pipe_stage_skid_reg #(
        .PAYLOAD_W    (PW),
        .CLEAR_INVALID(1'b1),
        .CNT_W        (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .bus      (bus),
        .count    (count),
        .stall_cnt(stall_cnt),
        .stall_clr(stall_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_cmp;
    int            n_bad;
    logic [PW-1:0] sb[$];
    logic          acc_s;
    logic          drn_s;
    logic [PW-1:0] dout_s;
    logic [PW-1:0] exp_d;

    // Sample the handshake mid-cycle, then advance past the next edge
    task automatic step();
        @(negedge clk);
        acc_s  = bus.in_valid & bus.in_ready;
        drn_s  = bus.out_valid & bus.out_ready;
        dout_s = bus.out_data;
        if (acc_s) sb.push_back(bus.in_data);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = PW'(16'h1234);
        step();
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
        end
        n_cmp++;
        if (bus.out_data !== '0) begin
            n_bad++;
            $display("FAIL rst_out_data: got %h want 0", bus.out_data);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_in_ready: got %b want 0", bus.in_ready);
        end
        n_cmp++;
        if (count !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_count: got %0d want 0", count);
        end
        n_cmp++;
        if (stall_cnt !== '0) begin
            n_bad++;
            $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt);
        end
        sb.delete();
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rel_in_ready: got %b want 1", bus.in_ready);
        end
        step();
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = PW'(i);
            step();
            if (drn_s) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL stream_sb: got %h want none", dout_s);
                end else begin
                    exp_d = sb.pop_front();
                    if (dout_s !== exp_d) begin
                        n_bad++;
                        $display("FAIL stream_sb: got %h want %h", dout_s, exp_d);
                    end
                end
            end
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== PW'(i)) begin
                n_bad++;
                $display("FAIL stream_lat: got %b/%h want 1/%h",
                         bus.out_valid, bus.out_data, PW'(i));
            end
            n_cmp++;
            if (count !== 2'd1 || bus.in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL stream_cnt: got %0d/%b want 1/1",
                         count, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        step();
        if (drn_s) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL stream_sb: got %h want none", dout_s);
            end else begin
                exp_d = sb.pop_front();
                if (dout_s !== exp_d) begin
                    n_bad++;
                    $display("FAIL stream_sb: got %h want %h", dout_s, exp_d);
                end
            end
        end
        n_cmp++;
        if (count !== 2'd0 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL stream_end: got count %0d left %0d want 0/0",
                     count, sb.size());
        end
    endtask

    task automatic test_skid();
        int got;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = PW'(71'h0A_AAAA_0000_1111_000A);
        step();
        bus.in_data = PW'(71'h0B_BBBB_0000_2222_000B);
        step();
        n_cmp++;
        if (count !== 2'd2 || bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL skid_full: got %0d/%b want 2/0",
                     count, bus.in_ready);
        end
        bus.in_data = PW'(71'h0C_CCCC_0000_3333_000C);
        step();
        n_cmp++;
        if (acc_s !== 1'b0 || count !== 2'd2) begin
            n_bad++;
            $display("FAIL skid_hold: got acc %b count %0d want 0/2",
                     acc_s, count);
        end
        n_cmp++;
        if (bus.out_data !== PW'(71'h0A_AAAA_0000_1111_000A)) begin
            n_bad++;
            $display("FAIL skid_stable: got %h want A", bus.out_data);
        end
        bus.out_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 10 && !(got == 3 && count == 2'd0); k++) begin
            step();
            if (acc_s) bus.in_valid = 1'b0;
            if (drn_s) begin
                got++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL skid_sb: got %h want none", dout_s);
                end else begin
                    exp_d = sb.pop_front();
                    if (dout_s !== exp_d) begin
                        n_bad++;
                        $display("FAIL skid_sb: got %h want %h", dout_s, exp_d);
                    end
                end
            end
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (got != 3 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL skid_total: got %0d beats left %0d want 3/0",
                     got, sb.size());
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = PW'(71'h11);
        step();
        bus.in_data = PW'(71'h22);
        step();
        bus.in_data = PW'(71'h33);
        flush = 1'b1;
        step();
        sb.delete();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (count !== 2'd0 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_full: got %0d/%b want 0/0",
                     count, bus.out_valid);
        end
        n_cmp++;
        if (bus.out_data !== '0 || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_out: got %h/%b want 0/1",
                     bus.out_data, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data = PW'(71'h44);
        step();
        bus.in_data = PW'(71'h55);
        flush = 1'b1;
        step();
        sb.delete();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (count !== 2'd0) begin
            n_bad++;
            $display("FAIL flush_one: got %0d want 0", count);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (drn_s !== 1'b0) begin
                n_bad++;
                $display("FAIL flush_leak: got beat %h want none", dout_s);
            end
        end
    endtask

    task automatic test_stall();
        int cexp;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = PW'(71'h0D);
        stall_clr = 1'b1;
        step();
        bus.in_valid = 1'b0;
        stall_clr = 1'b0;
        n_cmp++;
        if (stall_cnt !== 4'd0 || count !== 2'd1) begin
            n_bad++;
            $display("FAIL stall_init: got %0d/%0d want 0/1",
                     stall_cnt, count);
        end
        cexp = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (cexp < 15) cexp++;
            n_cmp++;
            if (stall_cnt !== CW'(cexp)) begin
                n_bad++;
                $display("FAIL stall_inc: got %0d want %0d", stall_cnt, cexp);
            end
        end
        stall_clr = 1'b1;
        step();
        stall_clr = 1'b0;
        n_cmp++;
        if (stall_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL stall_clr: got %0d want 0", stall_cnt);
        end
        step();
        n_cmp++;
        if (stall_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL stall_resume: got %0d want 1", stall_cnt);
        end
        bus.out_ready = 1'b1;
        step();
        if (drn_s) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL stall_sb: got %h want none", dout_s);
            end else begin
                exp_d = sb.pop_front();
                if (dout_s !== exp_d) begin
                    n_bad++;
                    $display("FAIL stall_sb: got %h want %h", dout_s, exp_d);
                end
            end
        end
        n_cmp++;
        if (stall_cnt !== 4'd1 || count !== 2'd0) begin
            n_bad++;
            $display("FAIL stall_drain: got %0d/%0d want 1/0",
                     stall_cnt, count);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = PW'(71'h0E);
        step();
        bus.in_data = PW'(71'h0F);
        step();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (count !== 2'd2) begin
            n_bad++;
            $display("FAIL rmid_fill: got %0d want 2", count);
        end
        reset = 1'b0;
        step();
        sb.delete();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            n_bad++;
            $display("FAIL rmid_out: got %b/%h want 0/0",
                     bus.out_valid, bus.out_data);
        end
        n_cmp++;
        if (count !== 2'd0 || stall_cnt !== '0 || bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_state: got %0d/%0d/%b want 0/0/0",
                     count, stall_cnt, bus.in_ready);
        end
        reset = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if (drn_s !== 1'b0) begin
                n_bad++;
                $display("FAIL rmid_leak: got beat %h want none", dout_s);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        flush = 1'b0;
        stall_clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        #1;
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid_reg.md
# pipe_stage_skid_reg

Parametrised, handshaked pipeline stage register that replaces the fixed-field stage registers between MIPS pipeline stages (e.g. Memory→Writeback). It carries an arbitrary packed payload with valid/ready flow control, a two-entry skid buffer so that no combinational path runs from `out_ready` to `in_ready`, a synchronous flush for hazard squashing, and a saturating stall-cycle counter for performance debug.

## Interface
- `PAYLOAD_W`, 71, packed payload width (71 = ALUOut 32 + ReadData 32 + WriteReg 5 + RegWrite 1 + MemtoReg 1).
- `CLEAR_INVALID`, 1, when 1 `out_data` is forced to zero whenever `out_valid`=0.
- `CNT_W`, 16, width of the stall counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  active-low reset, synchronous (sampled on the rising `clk` edge).
- `flush`  in  1  synchronous squash of all held entries.
- `in_valid`  in  1  upstream offers `in_data`.
- `in_data`  in  PAYLOAD_W  upstream payload.
- `in_ready`  out  1  stage can accept this cycle.
- `out_valid`  out  1  `out_data` is valid.
- `out_data`  out  PAYLOAD_W  downstream payload.
- `out_ready`  in  1  downstream consumes this cycle.
- `count`  out  2  number of held entries (0..2).
- `stall_cnt`  out  CNT_W  saturating count of cycles with `out_valid`=1 and `out_ready`=0.
- `stall_clr`  in  1  synchronous clear of `stall_cnt`.

## Operation
- Storage: main register (`m_valid`, `m_data`) drives the outputs. Skid register (`s_valid`, `s_data`) holds overflow.
- Accept = `in_valid & in_ready`. Drain = `out_valid & out_ready`.
- `in_ready` = `~s_valid & reset`. It is a pure function of registered state and `reset`.
- `out_valid` = `m_valid`. `out_data` = `m_data`, or 0 if `CLEAR_INVALID`=1 and `m_valid`=0.
- States (encoded by valids; `count` mirrors them):
  - EMPTY (0): accept → ONE, `m_data`←`in_data`.
  - ONE (1): accept & drain → ONE, `m_data`←`in_data`. Accept & no drain → FULL, `s_data`←`in_data`. Drain only → EMPTY. Neither → hold.
  - FULL (2): `in_ready`=0. Drain → ONE, `m_data`←`s_data`. Otherwise hold.
- Order is preserved: the skid entry always follows the main entry.
- Flush takes priority over every transition. Next state is EMPTY. Any beat accepted in the flush cycle is discarded. Data registers are cleared to 0.
- `stall_cnt`: increments when `out_valid & ~out_ready` and saturates at all-ones. `stall_clr` zeroes it (clear beats increment). Flush does not affect it.
- Reset (`reset`=0 at an edge) has priority over flush and `stall_clr`. All valids, data and `stall_cnt` go to 0. Reset asserted mid-transfer drops held entries without draining them.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `count`=0, `stall_cnt`=0. `in_ready`=0 while `reset`=0 and 1 in the first cycle after release.
- Latency: a beat accepted at edge N appears on `out_valid`/`out_data` after edge N (one cycle) when the stage was EMPTY, or when it was ONE with a simultaneous drain.
- Throughput: one beat per cycle sustained while `out_ready`=1.
- Backpressure: `in_ready` falls one cycle after the first un-drained accept in ONE, so at most one extra beat is absorbed.
- Valid/ready rules for upstream and downstream:
  - Upstream must hold `in_data` stable while `in_valid`=1 and `in_ready`=0.
  - This block holds `out_data` stable while `out_valid`=1 and `out_ready`=0.
- No combinational path exists from `in_*` to `out_*`, or from `out_ready` to `in_ready`.
- Flush with drain in the same cycle: the drained beat counts as consumed. State becomes EMPTY.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `in_valid`=1 and `in_data`=0x1234 → `out_valid`=0, `out_data`=0, `in_ready`=0, `count`=0. After release, `in_ready`=1.
- Streaming: send beats 1..8 on consecutive cycles with `out_ready`=1 → outputs appear 1..8, each one cycle after its accept, with `count` staying at 1 and no bubbles.
- Skid/backpressure: with `out_ready`=0, offer beats A, B, C.
  - Required response: A and B are accepted, `count`=2, and `in_ready`=0 while C is held.
  - Then raise `out_ready`: out sequence is A, B, C in order, with no loss or duplication.
- Flush: with FULL (A, B held), pulse `flush` together with `in_valid` on beat C → next cycle `count`=0, `out_valid`=0, `out_data`=0, `in_ready`=1. C is never output.
- Stall counter: with `CNT_W`=4, hold `out_valid`=1 and `out_ready`=0 for 20 cycles → `stall_cnt` saturates at 15. A `stall_clr` pulse gives 0 on the next cycle even with the stall ongoing.
- Reset mid-operation: in FULL, assert `reset`=0 for 1 cycle → all outputs return to reset values. Held beats are not emitted after release.
